// File: rtl/inst_pkg.sv
// Shared instruction field layout, format and loader state encodings.
// The decoder imports the same field constants so both sides agree on the word format.
package inst_pkg;

  localparam int OP_MSB        = 31;
  localparam int OP_LSB        = 25;
  localparam int RD_MSB        = 24;
  localparam int RD_LSB        = 20;
  localparam int RS1_MSB       = 19;
  localparam int RS1_LSB       = 15;
  localparam int RS2_MSB       = 14;
  localparam int RS2_LSB       = 10;
  localparam int OFFSET_MSB    = 14;
  localparam int OFFSET_LSB    = 0;
  localparam int OFFSET_LO_MSB = 9;
  localparam int OFFSET_LO_LSB = 0;

  typedef enum logic {FMT_R = 1'b0, FMT_M = 1'b1} fmt_e;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  // R-format keeps rs2 and the low offset bits; M-format spends rs2's slot on a wider offset.
  function automatic logic [31:0] pack_inst(input fmt_e fmt, input logic [6:0] op,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [14:0] offset);
    logic [31:0] w;
    w = '0;
    w[OP_MSB:OP_LSB]   = op;
    w[RD_MSB:RD_LSB]   = rd;
    w[RS1_MSB:RS1_LSB] = rs1;
    if (fmt == FMT_M) begin
      w[OFFSET_MSB:OFFSET_LSB] = offset;
    end else begin
      w[RS2_MSB:RS2_LSB]             = rs2;
      w[OFFSET_LO_MSB:OFFSET_LO_LSB] = offset[OFFSET_LO_MSB:OFFSET_LO_LSB];
    end
    return w;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO of packed instruction words; storage clears on reset so the
// head reads zero when empty.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign cnt   = wr_ptr_q - rd_ptr_q;
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign dout  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder / program loader: packs field tuples, buffers them and writes
// them to instruction memory at consecutive addresses from a captured base.
module inst_encoder
  import inst_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_fmt,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [14:0]       in_offset,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              wrap_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wrap_err_q, wrap_err_d;
  logic              last_seen_q, last_seen_d;

  logic              push, pop, fifo_full, fifo_empty, drained;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [31:0]       packed_word, fifo_head;

  assign packed_word = pack_inst(fmt_e'(in_fmt), in_op, in_rd, in_rs1, in_rs2, in_offset);

  assign in_ready  = (state_q == ST_RUN) && !fifo_full && !last_seen_q;
  assign push      = in_valid && in_ready;
  assign mem_we    = (state_q == ST_RUN) && !fifo_empty;
  assign pop       = mem_we && mem_ready;
  assign mem_addr  = addr_q;
  assign mem_wdata = fifo_head;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign count     = count_q;
  assign wrap_err  = wrap_err_q;

  // Look ahead at the post-pop occupancy so DONE follows the final write directly.
  assign drained = fifo_empty || ((fifo_cnt == CNT_W'(1)) && pop);

  inst_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (packed_word),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    wrap_err_d  = wrap_err_q;
    last_seen_d = last_seen_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          addr_d      = base_addr;
          count_d     = '0;
          wrap_err_d  = 1'b0;
          last_seen_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (push && in_last) last_seen_d = 1'b1;
        if (pop) begin
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (&addr_q) wrap_err_d = 1'b1;
        end
        if (last_seen_q && drained) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      wrap_err_q  <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      wrap_err_q  <= wrap_err_d;
      last_seen_q <= last_seen_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed and randomized sessions against a transaction-level queue model of the loader.
module tb_inst_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_fmt = 1'b0;
  logic [6:0]        in_op = '0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [14:0]       in_offset = '0;
  logic              in_last = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready = 1'b1;
  logic              busy, done, wrap_err;
  logic [ADDR_W:0]   count;

  inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_offset(in_offset),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .count(count), .wrap_err(wrap_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 run, 2 done; queue holds words awaiting write.
  logic [31:0]       mq[$];
  int                phase;
  logic [ADDR_W-1:0] m_addr;
  int                m_count;
  bit                m_wrap, m_last;

  bit                acc, wr, saw_done;
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] last_wa;
  logic [31:0]       last_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_pack(input bit fmt, input int unsigned op, input int unsigned rd,
                                           input int unsigned rs1, input int unsigned rs2,
                                           input int unsigned off);
    int unsigned w;
    w = op * (2**25) + rd * (2**20) + rs1 * (2**15);
    if (fmt) w += off % 32768;
    else     w += rs2 * 1024 + off % 1024;
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    phase = 0; m_addr = '0; m_count = 0; m_wrap = 0; m_last = 0;
  endtask

  task automatic rand_fields();
    in_fmt = 1'($urandom); in_op = 7'($urandom); in_rd = 5'($urandom);
    in_rs1 = 5'($urandom); in_rs2 = 5'($urandom); in_offset = 15'($urandom);
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic cycle();
    bit exp_rdy, exp_we, last_now;
    int nph;
    @(negedge clk);
    acc = 0; wr = 0;
    exp_rdy = (phase == 1) && (mq.size() < DEPTH) && !m_last;
    exp_we  = (phase == 1) && (mq.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("mem_we",   32'(mem_we),   32'(exp_we));
    chk("busy",     32'(busy),     32'(phase == 1));
    chk("done",     32'(done),     32'(phase == 2));
    chk("count",    32'(count),    32'(m_count));
    chk("wrap_err", 32'(wrap_err), 32'(m_wrap));
    if (exp_we) begin
      chk("mem_addr",  32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", mem_wdata,     mq[0]);
    end
    if (done === 1'b1) saw_done = 1;
    nph = phase;
    case (phase)
      0: if (start) begin
        nph = 1; m_addr = base_addr; m_count = 0; m_wrap = 0; m_last = 0;
      end
      1: begin
        last_now = m_last;
        if (exp_we && mem_ready) begin
          wr = 1; wr_cnt++; last_wa = mem_addr; last_wd = mem_wdata;
          void'(mq.pop_front());
          if (int'(m_addr) == 2**ADDR_W - 1) m_wrap = 1;
          m_addr = m_addr + 1'b1;
          m_count++;
        end
        if (in_valid && exp_rdy) begin
          acc = 1;
          mq.push_back(ref_pack(in_fmt, in_op, in_rd, in_rs1, in_rs2, in_offset));
          if (in_last) m_last = 1;
        end
        if (last_now && mq.size() == 0) nph = 2;
      end
      default: nph = 0;
    endcase
    phase = nph;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic start_session(input logic [ADDR_W-1:0] b);
    start = 1'b1; base_addr = b;
    cycle();
    start = 1'b0;
  endtask

  task automatic send(input bit f, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [14:0] off, input bit last);
    in_fmt = f; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_offset = off;
    in_last = last; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (acc) break;
    end
    chk("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    saw_done = 0;
    for (int c = 0; c < bound && !saw_done; c++) cycle();
    chk("done_seen", 32'(saw_done), 32'd1);
  endtask

  // Drive n tuples with random valid/ready gaps; junk valids after the last must be ignored.
  task automatic feed(input int n, input int vpct, input int rpct, input int bound);
    int sent;
    sent = 0; saw_done = 0;
    rand_fields(); in_last = (n == 1);
    for (int c = 0; c < bound && !saw_done; c++) begin
      in_valid  = (sent < n) ? ($urandom_range(99) < vpct) : 1'($urandom);
      mem_ready = ($urandom_range(99) < rpct);
      cycle();
      if (acc) begin
        sent++; rand_fields(); in_last = (sent == n - 1);
      end
    end
    in_valid = 1'b0; mem_ready = 1'b1;
    chk("feed_sent", 32'(sent), 32'(n));
    chk("feed_done", 32'(saw_done), 32'd1);
  endtask

  initial begin
    int idx, w0;
    do_reset();
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_wrap_err",  32'(wrap_err),  32'd0);

    // valid before any start is refused
    w0 = wr_cnt;
    rand_fields(); in_valid = 1'b1;
    repeat (3) cycle();
    in_valid = 1'b0;
    chk("pre_start_writes", 32'(wr_cnt - w0), 32'd0);

    // R-format single word
    start_session(8'h10);
    send(1'b0, 7'h05, 5'd3, 5'd7, 5'd9, 15'h01FF, 1'b1);
    wait_done(10);
    chk("r_wdata", last_wd, 32'h0A33A5FF);
    chk("r_addr",  32'(last_wa), 32'h10);
    chk("r_count", 32'(count), 32'd1);

    // M-format, rs2 must not leak into the word
    start_session(8'h00);
    send(1'b1, 7'h7F, 5'd31, 5'd0, 5'd21, 15'h7FFF, 1'b1);
    wait_done(10);
    chk("m_wdata", last_wd, 32'hFFF07FFF);

    // backpressure: only DEPTH tuples fit while memory stalls
    start_session(8'h50);
    w0 = wr_cnt; idx = 0;
    mem_ready = 1'b0; in_valid = 1'b1; rand_fields(); in_last = 1'b0;
    repeat (10) begin
      cycle();
      if (acc) begin idx++; rand_fields(); in_last = (idx == 5); end
    end
    chk("bp_accepts", 32'(idx), 32'd4);
    chk("bp_stall_writes", 32'(wr_cnt - w0), 32'd0);
    mem_ready = 1'b1; saw_done = 0;
    for (int c = 0; c < 40 && !saw_done; c++) begin
      cycle();
      if (acc) begin idx++; rand_fields(); in_last = (idx == 5); if (idx == 6) in_valid = 1'b0; end
    end
    in_valid = 1'b0;
    chk("bp_done", 32'(saw_done), 32'd1);
    chk("bp_total_writes", 32'(wr_cnt - w0), 32'd6);
    chk("bp_last_addr", 32'(last_wa), 32'h55);
    chk("bp_count", 32'(count), 32'd6);

    // address wrap
    start_session(8'hFE);
    feed(3, 100, 100, 30);
    chk("wrap_flag", 32'(wrap_err), 32'd1);
    chk("wrap_last_addr", 32'(last_wa), 32'h00);
    start_session(8'h00);
    chk("wrap_cleared", 32'(wrap_err), 32'd0);
    feed(1, 100, 100, 20);

    // start while running is ignored
    start_session(8'h40);
    start = 1'b1; base_addr = 8'h80;
    cycle();
    start = 1'b0;
    feed(2, 100, 100, 30);
    chk("run_start_addr", 32'(last_wa), 32'h41);

    // reset after two of five writes
    start_session(8'h20);
    w0 = wr_cnt;
    in_valid = 1'b1; mem_ready = 1'b1; rand_fields(); in_last = 1'b0;
    for (int c = 0; c < 20 && (wr_cnt - w0) < 2; c++) begin
      cycle();
      if (acc) rand_fields();
    end
    in_valid = 1'b0;
    chk("mid_writes", 32'(wr_cnt - w0), 32'd2);
    do_reset();
    chk("mid_rst_count",  32'(count),  32'd0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_busy",   32'(busy),   32'd0);
    saw_done = 0;
    repeat (4) cycle();
    chk("mid_rst_no_done", 32'(saw_done), 32'd0);
    start_session(8'h30);
    feed(2, 100, 100, 30);
    chk("post_rst_addr", 32'(last_wa), 32'h31);

    // randomized sessions
    for (int s = 0; s < 15; s++) begin
      start_session(8'($urandom));
      feed($urandom_range(8, 1), 70, 70, 300);
      repeat ($urandom_range(3)) begin
        in_valid = 1'($urandom); cycle();
      end
      in_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
